// File: rtl/entry_time_logger_pkg.sv
// parking_pkg: shared widths, defaults and types for the parking-duration datapath
package parking_pkg;
  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;
  localparam int TIME_W    = 8;
  localparam int TICK_DIV  = 4;
  typedef logic [TIME_W-1:0] time_t;
  typedef logic [SLOT_W-1:0] slot_t;
endpackage

// File: rtl/entry_time_logger_if.sv
// entry_time_logger_if: strobe inputs and timestamp/occupancy outputs of the entry logger
interface entry_time_logger_if;
  import parking_pkg::*;
  logic                 car_in;
  slot_t                in_slot;
  logic                 car_out;
  slot_t                out_slot;
  time_t                time_in;
  time_t                time_out;
  logic                 out_valid;
  logic                 err_in_occupied;
  logic                 err_out_empty;
  logic [NUM_SLOTS-1:0] occupied;
  time_t                now;
  modport master (
    output car_in, in_slot, car_out, out_slot,
    input  time_in, time_out, out_valid, err_in_occupied, err_out_empty, occupied, now
  );
  modport slave (
    input  car_in, in_slot, car_out, out_slot,
    output time_in, time_out, out_valid, err_in_occupied, err_out_empty, occupied, now
  );
endinterface

// File: rtl/entry_time_logger_time_base.sv
// parking_time_base: prescaler dividing clk by DIV, driving a wrapping parking-time counter
module parking_time_base
  import parking_pkg::*;
#(
  parameter int DIV = TICK_DIV
) (
  input  logic  clk,
  input  logic  rst,
  output time_t o_now,
  output logic  o_tick
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [PW-1:0] r_pre;
  time_t         r_now;
  assign o_tick = (r_pre == PW'(DIV - 1));
  assign o_now  = r_now;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_now <= '0;
    end else if (o_tick) begin
      r_pre <= '0;
      r_now <= r_now + time_t'(1);
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end
endmodule

// File: rtl/entry_time_logger.sv
// entry_time_logger: per-slot entry stamps and occupancy; emits (time_in, time_out) on exit
module entry_time_logger
  import parking_pkg::*;
(
  input logic                clk,
  input logic                rst,
  entry_time_logger_if.slave bus
);
  time_t                w_now;
  logic                 w_unused_tick;
  logic                 w_out_ok;
  logic                 w_in_ok;
  logic [NUM_SLOTS-1:0] w_occ_nxt;
  time_t                r_stamp [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_occ;
  time_t                r_time_in;
  time_t                r_time_out;
  logic                 r_out_valid;
  logic                 r_err_in;
  logic                 r_err_out;
  parking_time_base #(.DIV(TICK_DIV)) u_time_base (
    .clk    (clk),
    .rst    (rst),
    .o_now  (w_now),
    .o_tick (w_unused_tick)
  );
  // Exit is resolved on pre-cycle occupancy, so a same-slot exit frees the slot for re-entry.
  always_comb begin
    w_out_ok  = bus.car_out && r_occ[bus.out_slot];
    w_in_ok   = bus.car_in && (!r_occ[bus.in_slot] || (w_out_ok && bus.out_slot == bus.in_slot));
    w_occ_nxt = (r_occ & ~(w_out_ok ? NUM_SLOTS'(1) << bus.out_slot : '0))
              | (w_in_ok ? NUM_SLOTS'(1) << bus.in_slot : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ       <= '0;
      r_time_in   <= '0;
      r_time_out  <= '0;
      r_out_valid <= 1'b0;
      r_err_in    <= 1'b0;
      r_err_out   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) r_stamp[i] <= '0;
    end else begin
      r_occ       <= w_occ_nxt;
      r_out_valid <= w_out_ok;
      r_err_in    <= bus.car_in && !w_in_ok;
      r_err_out   <= bus.car_out && !w_out_ok;
      if (w_out_ok) begin
        r_time_in  <= r_stamp[bus.out_slot];
        r_time_out <= w_now;
      end
      if (w_in_ok) r_stamp[bus.in_slot] <= w_now;
    end
  end
  assign bus.time_in         = r_time_in;
  assign bus.time_out        = r_time_out;
  assign bus.out_valid       = r_out_valid;
  assign bus.err_in_occupied = r_err_in;
  assign bus.err_out_empty   = r_err_out;
  assign bus.occupied        = r_occ;
  assign bus.now             = w_now;
endmodule

// File: tb/tb_entry_time_logger.sv
// tb_entry_time_logger: scoreboard bench; driver pushes model expectations, monitor pops and compares
module tb_entry_time_logger;
  import parking_pkg::*;
  typedef struct {
    logic v;
    logic ei;
    logic eo;
    int   tin;
    int   tout;
    int   occ;
    int   now;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  entry_time_logger_if bus ();
  entry_time_logger dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k        = 0;
  bit   m_occ   [NUM_SLOTS];
  int   m_stamp [NUM_SLOTS];
  int   m_tin    = 0;
  int   m_tout   = 0;
  localparam int TMOD = 1 << TIME_W;
  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction
  function automatic int model_now();
    return (k / TICK_DIV) % TMOD;
  endfunction
  // Model: now is elapsed clk cycles over TICK_DIV; exit is handled before entry.
  task automatic step(bit r, bit ci, int is, bit co, int os);
    exp_t e;
    int   now_pre;
    @(negedge clk);
    rst          = r;
    bus.car_in   = ci;
    bus.in_slot  = slot_t'(is);
    bus.car_out  = co;
    bus.out_slot = slot_t'(os);
    now_pre = model_now();
    e.v = 0; e.ei = 0; e.eo = 0;
    if (r) begin
      k = 0;
      foreach (m_occ[i]) begin m_occ[i] = 0; m_stamp[i] = 0; end
      m_tin = 0; m_tout = 0;
    end else begin
      k++;
      if (co) begin
        if (m_occ[os]) begin
          e.v = 1; m_tin = m_stamp[os]; m_tout = now_pre; m_occ[os] = 0;
        end else e.eo = 1;
      end
      if (ci) begin
        if (m_occ[is]) e.ei = 1;
        else begin m_occ[is] = 1; m_stamp[is] = now_pre; end
      end
    end
    e.tin = m_tin; e.tout = m_tout; e.now = model_now(); e.occ = 0;
    foreach (m_occ[i]) if (m_occ[i]) e.occ |= (1 << i);
    q.push_back(e);
  endtask
  task automatic idle_until(int t);
    int guard = 0;
    while (model_now() != t && guard < 4000) begin
      step(0, 0, 0, 0, 0);
      guard++;
    end
    if (guard >= 4000) begin
      n_fail++;
      $display("FAIL idle_until: now %0d never reached %0d", model_now(), t);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("out_valid", 32'(bus.out_valid), 32'(e.v));
        check("err_in_occupied", 32'(bus.err_in_occupied), 32'(e.ei));
        check("err_out_empty", 32'(bus.err_out_empty), 32'(e.eo));
        check("time_in", 32'(bus.time_in), e.tin);
        check("time_out", 32'(bus.time_out), e.tout);
        check("occupied", 32'(bus.occupied), e.occ);
        check("now", 32'(bus.now), e.now);
        if (e.v) check("total", 32'((bus.time_out - bus.time_in) & 8'hff), (e.tout - e.tin + TMOD) % TMOD);
      end
    end
  end
  initial begin
    bus.car_in = 0; bus.in_slot = '0; bus.car_out = 0; bus.out_slot = '0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (40) step(0, 0, 0, 0, 0);
    idle_until(5);   step(0, 1, 2, 0, 0);
    idle_until(17);  step(0, 0, 0, 1, 2);
    idle_until(250); step(0, 1, 0, 0, 0);
    idle_until(4);   step(0, 0, 0, 1, 0);
    step(0, 1, 3, 0, 0);
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 3);
    step(0, 0, 0, 1, 6);
    idle_until(7);   step(0, 1, 1, 0, 0);
    idle_until(20);  step(0, 1, 1, 1, 1);
    idle_until(30);  step(0, 0, 0, 1, 1);
    step(0, 1, 5, 1, 5);
    step(0, 1, 6, 1, 2);
    step(0, 1, 4, 0, 0);
    step(1, 1, 7, 1, 4);
    step(0, 0, 0, 1, 4);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, NUM_SLOTS - 1),
           $urandom_range(0, 2) == 0, $urandom_range(0, NUM_SLOTS - 1));
    step(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
